// File: rtl/angulos_pkg.sv
// Shared constants for the angle-label ROM: address/data widths and the
// ASCII text table ("020" .. "160", step 20 degrees), most significant char first.
package angulos_pkg;

    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 24;
    localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;

    typedef logic [ROM_DATA_W-1:0] ascii3_t;

    // Entry i is the decimal text of 20*(i+1), char2 in [23:16], char0 in [7:0].
    localparam ascii3_t ANGULOS [ROM_DEPTH] = '{
        24'h303230,  // "020"
        24'h303430,  // "040"
        24'h303630,  // "060"
        24'h303830,  // "080"
        24'h313030,  // "100"
        24'h313230,  // "120"
        24'h313430,  // "140"
        24'h313630   // "160"
    };

endpackage

// File: rtl/rom_angulos_8x24.sv
// Angle-label ROM: maps the position index to its 3-char ASCII angle text.
// Latency: saida is combinational (0 cycles); saida_reg/saida_valid lag by 1 cycle.
// Backpressure: none; the registered copy loads on every rising edge out of reset.
module rom_angulos_8x24
    import angulos_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ROM_ADDR_W-1:0] endereco,
    output logic [ROM_DATA_W-1:0] saida,
    output logic [ROM_DATA_W-1:0] saida_reg,
    output logic                  saida_valid
);

    logic [ROM_DATA_W-1:0] tabela_angulos [0:ROM_DEPTH-1];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_tabela
        assign tabela_angulos[i] = ANGULOS[i];
    end

    // Read path deliberately touches neither clock nor reset_n.
    assign saida = tabela_angulos[endereco];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            saida_reg   <= '0;
            saida_valid <= 1'b0;
        end else begin
            saida_reg   <= tabela_angulos[endereco];
            saida_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_angulos_8x24.sv
// Bench for rom_angulos_8x24: table sweep, reset/edge corner cases, random traffic.
module tb_rom_angulos_8x24;

    logic        clock;
    logic        reset_n;
    logic [2:0]  endereco;
    logic [23:0] saida;
    logic [23:0] saida_reg;
    logic        saida_valid;
    logic        clk_en;

    int total = 0;
    int bad   = 0;

    rom_angulos_8x24 dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .endereco    (endereco),
        .saida       (saida),
        .saida_reg   (saida_reg),
        .saida_valid (saida_valid)
    );

    always #5 if (clk_en) clock = ~clock;

    typedef struct {
        logic [2:0]  addr;
        logic [23:0] exp;
    } vec_t;

    vec_t vt [8];

    // Reference: decimal text of 20*(addr+1), built digit by digit.
    function automatic logic [23:0] model_word(input int a);
        int v;
        logic [7:0] c2, c1, c0;
        v  = 20 * (a + 1);
        c2 = 8'h30 + 8'((v / 100) % 10);
        c1 = 8'h30 + 8'((v / 10) % 10);
        c0 = 8'h30 + 8'(v % 10);
        return {c2, c1, c0};
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    int          a;
    int          dec;
    logic [7:0]  ch;
    logic [23:0] w;
    logic [23:0] m_reg;
    logic        m_valid;
    logic        rst_ev;

    initial begin
        vt[0] = '{3'd0, 24'h303230};
        vt[1] = '{3'd1, 24'h303430};
        vt[2] = '{3'd2, 24'h303630};
        vt[3] = '{3'd3, 24'h303830};
        vt[4] = '{3'd4, 24'h313030};
        vt[5] = '{3'd5, 24'h313230};
        vt[6] = '{3'd6, 24'h313430};
        vt[7] = '{3'd7, 24'h313630};

        clock    = 1'b0;
        clk_en   = 1'b0;
        reset_n  = 1'b0;
        endereco = 3'd0;
        #1;
        chk("reset_saida_reg", saida_reg, 24'h0);
        chk("reset_saida_valid", {23'h0, saida_valid}, 24'h0);

        // Static sweep with the clock held still.
        for (int i = 0; i < 8; i++) begin
            endereco = vt[i].addr;
            #10;
            chk($sformatf("sweep_const_%0d", i), saida, vt[i].exp);
            chk($sformatf("sweep_model_%0d", i), saida, model_word(i));
            chk($sformatf("tabela_%0d", i), dut.tabela_angulos[i], vt[i].exp);
            dec = 0;
            w   = saida;
            for (int k = 2; k >= 0; k--) begin
                ch = w[8*k +: 8];
                total++;
                if (ch < 8'h30 || ch > 8'h39) begin
                    bad++;
                    $display("FAIL digit_%0d_%0d actual=%h required=30..39", i, k, ch);
                end
                dec = dec * 10 + int'(ch - 8'h30);
            end
            chk($sformatf("decode_%0d", i), 24'(dec), 24'(20 * (i + 1)));
        end

        // Reset held low while the clock runs.
        clk_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_clk_saida_reg", saida_reg, 24'h0);
        chk("rst_clk_saida_valid", {23'h0, saida_valid}, 24'h0);
        endereco = 3'd5;
        #1;
        chk("rst_clk_saida_tracks", saida, 24'h313230);

        // Release reset, one edge loads the word.
        @(negedge clock);
        endereco = 3'd3;
        reset_n  = 1'b1;
        @(posedge clock);
        #1;
        chk("release_saida_reg", saida_reg, 24'h303830);
        chk("release_saida_valid", {23'h0, saida_valid}, 24'h1);

        // Address change between edges: combinational moves, register waits.
        @(negedge clock);
        endereco = 3'd7;
        @(posedge clock);
        #1;
        chk("seq7_saida_reg", saida_reg, 24'h313630);
        @(negedge clock);
        endereco = 3'd0;
        #1;
        chk("seq0_saida_now", saida, 24'h303230);
        chk("seq0_saida_reg_held", saida_reg, 24'h313630);
        @(posedge clock);
        #1;
        chk("seq0_saida_reg_next", saida_reg, 24'h303230);

        // Asynchronous clear in the middle of a cycle.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_saida_reg", saida_reg, 24'h0);
        chk("async_saida_valid", {23'h0, saida_valid}, 24'h0);
        chk("async_saida_tracks", saida, 24'h303230);

        // Randomised traffic against the reference, with occasional async resets.
        m_reg   = '0;
        m_valid = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            reset_n  = 1'b1;
            a        = int'($urandom_range(0, 7));
            endereco = 3'(a);
            rst_ev   = ($urandom_range(0, 15) == 0);
            #1;
            chk($sformatf("rnd_saida_%0d", n), saida, model_word(a));
            if (rst_ev) begin
                reset_n = 1'b0;
                #1;
                m_reg   = '0;
                m_valid = 1'b0;
                chk($sformatf("rnd_async_reg_%0d", n), saida_reg, 24'h0);
                chk($sformatf("rnd_async_valid_%0d", n), {23'h0, saida_valid}, 24'h0);
            end
            @(posedge clock);
            #1;
            if (reset_n) begin
                m_reg   = model_word(a);
                m_valid = 1'b1;
            end
            chk($sformatf("rnd_reg_%0d", n), saida_reg, m_reg);
            chk($sformatf("rnd_valid_%0d", n), {23'h0, saida_valid}, {23'h0, m_valid});
        end

        clk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
